// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: double-buffered, run-time reloadable FIR coefficient bank.
// A serial valid/ready port fills a shadow bank; a commit request copies the
// shadow bank into the active bank only on a sample_tick, so the MAC stage
// never sees a mixed kernel. The active bank resets to the default low-pass kernel.
// Optional feature: define FIR_COEFF_SYM_EN to load only NTAPS/2 words and
// mirror them into the upper half of the active bank on swap.
module fir_coeff_bank #(
  parameter int NTAPS = 16,
  parameter int CW    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [CW-1:0]       load_data,
  input  logic                load_last,
  input  logic                commit,
  input  logic                sample_tick,
  output logic [NTAPS*CW-1:0] coeff_bus,
  output logic                swap_done,
  output logic                load_err,
  output logic                pending
);

`ifdef FIR_COEFF_SYM_EN
  localparam int L = NTAPS / 2;
`else
  localparam int L = NTAPS;
`endif
  localparam int PW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FULL,
    S_WAIT_TICK
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   shadow_q [L];
  logic [CW-1:0]   shadow_d [L];
  logic [CW-1:0]   active_q [NTAPS];
  logic [CW-1:0]   active_d [NTAPS];
  logic            swap_done_q, swap_done_d;
  logic            load_err_q, load_err_d;
  logic            pending_q, pending_d;
  logic            accept;
  logic            do_swap;
  logic            do_err;

  // Default symmetric low-pass kernel for the 16-tap build; zero otherwise.
  function automatic logic [CW-1:0] default_tap(input int unsigned k);
    logic [CW-1:0] v;
    v = '0;
    if (NTAPS == 16) begin
      case (k)
        0, 15:   v = CW'(-84);
        1, 14:   v = CW'(-53);
        2, 13:   v = CW'(120);
        3, 12:   v = CW'(240);
        4, 11:   v = CW'(350);
        5, 10:   v = CW'(420);
        6, 9:    v = CW'(450);
        7, 8:    v = CW'(460);
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  assign load_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept     = load_valid & load_ready;
  assign swap_done  = swap_done_q;
  assign load_err   = load_err_q;
  assign pending    = pending_q;

  // Next-state, write-pointer, shadow-write and swap decisions.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    pending_d   = pending_q;
    swap_done_d = 1'b0;
    load_err_d  = 1'b0;
    do_swap     = 1'b0;
    do_err      = 1'b0;
    for (int unsigned i = 0; i < L; i++) begin
      shadow_d[i] = shadow_q[i];
    end

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          shadow_d[wr_ptr_q] = load_data;
          if (wr_ptr_q == PW'(L - 1)) begin
            wr_ptr_d = '0;
            if (load_last) begin
              state_d = S_FULL;
            end else begin
              do_err = 1'b1;
            end
          end else if (load_last) begin
            do_err = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            state_d  = S_LOAD;
          end
        end
      end
      S_FULL: begin
        if (commit) begin
          // A coincident tick swaps on this same edge and skips WAIT_TICK.
          if (sample_tick) begin
            do_swap = 1'b1;
            state_d = S_IDLE;
          end else begin
            pending_d = 1'b1;
            state_d   = S_WAIT_TICK;
          end
        end
      end
      S_WAIT_TICK: begin
        if (sample_tick) begin
          do_swap   = 1'b1;
          pending_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_err) begin
      load_err_d = 1'b1;
      wr_ptr_d   = '0;
      state_d    = S_IDLE;
    end
    swap_done_d = do_swap;
  end

  // Active bank update: whole kernel replaced on the swap edge only.
  always_comb begin
    for (int unsigned k = 0; k < NTAPS; k++) begin
      active_d[k] = active_q[k];
      if (do_swap) begin
        if (k < L) begin
          active_d[k] = shadow_q[k];
        end else begin
          active_d[k] = shadow_q[NTAPS - 1 - k];
        end
      end
    end
  end

  // Coefficients leave straight from the active registers.
  always_comb begin
    coeff_bus = '0;
    for (int unsigned k = 0; k < NTAPS; k++) begin
      coeff_bus[k*CW +: CW] = active_q[k];
    end
  end

  // State registers; reset restores the default kernel and clears the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      swap_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      pending_q   <= 1'b0;
      for (int unsigned i = 0; i < L; i++) begin
        shadow_q[i] <= '0;
      end
      for (int unsigned k = 0; k < NTAPS; k++) begin
        active_q[k] <= default_tap(k);
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      swap_done_q <= swap_done_d;
      load_err_q  <= load_err_d;
      pending_q   <= pending_d;
      for (int unsigned i = 0; i < L; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
      for (int unsigned k = 0; k < NTAPS; k++) begin
        active_q[k] <= active_d[k];
      end
    end
  end

endmodule

// File: tb/tb_fir_coeff_bank.sv
// Self-checking bench for fir_coeff_bank with a transaction-level kernel model.
module tb_fir_coeff_bank;
  localparam int NTAPS = 16;
  localparam int CW    = 16;
`ifdef FIR_COEFF_SYM_EN
  localparam int L = NTAPS / 2;
  localparam bit SYM = 1'b1;
`else
  localparam int L = NTAPS;
  localparam bit SYM = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                load_valid = 1'b0;
  logic                load_ready;
  logic [CW-1:0]       load_data = '0;
  logic                load_last = 1'b0;
  logic                commit = 1'b0;
  logic                sample_tick = 1'b0;
  logic [NTAPS*CW-1:0] coeff_bus;
  logic                swap_done;
  logic                load_err;
  logic                pending;

  fir_coeff_bank #(.NTAPS(NTAPS), .CW(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_last   (load_last),
    .commit      (commit),
    .sample_tick (sample_tick),
    .coeff_bus   (coeff_bus),
    .swap_done   (swap_done),
    .load_err    (load_err),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int def_k [NTAPS] = '{-84, -53, 120, 240, 350, 420, 450, 460,
                        460, 450, 420, 350, 240, 120, -53, -84};
  logic [CW-1:0] exp_bus [NTAPS];
  logic [CW-1:0] kern [NTAPS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_bus(input string tag);
    for (int k = 0; k < NTAPS; k++) begin
      check($sformatf("%s tap%0d", tag, k), 32'(coeff_bus[k*CW +: CW]), 32'(exp_bus[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_default();
    for (int k = 0; k < NTAPS; k++) exp_bus[k] = def_k[k][CW-1:0];
  endtask

  // Kernel word k drives taps k and (with symmetry) its mirror.
  task automatic model_swap();
    for (int k = 0; k < NTAPS; k++) exp_bus[k] = (k < L) ? kern[k] : kern[NTAPS-1-k];
  endtask

  task automatic random_kernel();
    for (int i = 0; i < NTAPS; i++) kern[i] = CW'($urandom);
  endtask

  // Send n words with load_last on word index last_at (-1: never), random gaps.
  task automatic load_words(input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
        load_data  = CW'($urandom);
        load_last  = 1'($urandom);
        step();
      end
      check("ready_during_load", 32'(load_ready), 32'd1);
      load_valid = 1'b1;
      load_data  = kern[i];
      load_last  = (i == last_at);
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic load_good();
    load_words(L, L - 1);
    check("full_no_err", 32'(load_err), 32'd0);
    check("full_ready", 32'(load_ready), 32'd0);
    // A word offered while full must be ignored.
    load_valid = 1'b1;
    load_data  = CW'($urandom);
    load_last  = 1'b1;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
    check("full_ignores_word_err", 32'(load_err), 32'd0);
    check("full_ignores_word_ready", 32'(load_ready), 32'd0);
    check_bus("full_bus_old");
  endtask

  task automatic load_bad(input bit early_last);
    int e;
    if (early_last) begin
      e = $urandom_range(0, L - 2);
      load_words(e + 1, e);
    end else begin
      load_words(L, -1);
    end
    check("err_pulse", 32'(load_err), 32'd1);
    check("err_ready", 32'(load_ready), 32'd1);
    step();
    check("err_pulse_end", 32'(load_err), 32'd0);
    // Commit and tick after an aborted load must not touch the active bank.
    commit      = 1'b1;
    sample_tick = 1'b1;
    step();
    commit      = 1'b0;
    sample_tick = 1'b0;
    check("err_no_swap", 32'(swap_done), 32'd0);
    check("err_no_pending", 32'(pending), 32'd0);
    step();
    check("err_no_swap2", 32'(swap_done), 32'd0);
    check_bus("err_bus_kept");
  endtask

  // Commit, then tick after 'delay' pending cycles (0 = same-cycle tick).
  task automatic commit_swap(input int delay);
    commit      = 1'b1;
    sample_tick = (delay == 0);
    step();
    commit      = 1'b0;
    sample_tick = 1'b0;
    for (int i = 0; i < delay; i++) begin
      check("pending_high", 32'(pending), 32'd1);
      check("pending_no_swap", 32'(swap_done), 32'd0);
      check("pending_ready", 32'(load_ready), 32'd0);
      check_bus("pending_bus_old");
      commit      = 1'($urandom);
      sample_tick = (i == delay - 1);
      step();
      commit      = 1'b0;
      sample_tick = 1'b0;
    end
    model_swap();
    check("swap_done_high", 32'(swap_done), 32'd1);
    check("swap_pending_low", 32'(pending), 32'd0);
    check("swap_ready", 32'(load_ready), 32'd1);
    check_bus("swap_bus_new");
    step();
    check("swap_done_low", 32'(swap_done), 32'd0);
    check_bus("swap_bus_held");
  endtask

  initial begin
    model_default();
    step();
    step();
    #2 rst_n = 1'b1;
    step();
    check("rst_ready", 32'(load_ready), 32'd1);
    check("rst_swap_done", 32'(swap_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check_bus("rst_bus");

    // Directed kernel: 1..16, or 10..80 with symmetry.
    for (int i = 0; i < NTAPS; i++) kern[i] = SYM ? CW'(10 * (i + 1)) : CW'(i + 1);
    load_good();
    commit_swap(3);

    // load_last on word 5.
    random_kernel();
    load_words(5, 4);
    check("err5_pulse", 32'(load_err), 32'd1);
    step();
    commit      = 1'b1;
    sample_tick = 1'b1;
    step();
    commit      = 1'b0;
    sample_tick = 1'b0;
    check("err5_no_swap", 32'(swap_done), 32'd0);
    check_bus("err5_bus_kept");

    load_bad(1'b0);

    // Same-cycle commit and tick.
    random_kernel();
    load_good();
    commit_swap(0);

    for (int it = 0; it < 8; it++) begin
      random_kernel();
      case ($urandom_range(0, 3))
        0: load_bad(1'b1);
        1: load_bad(1'b0);
        default: begin
          load_good();
          commit_swap($urandom_range(0, 4));
        end
      endcase
    end

    // Reset while waiting for the tick.
    for (int i = 0; i < NTAPS; i++) kern[i] = 16'h7FFF;
    load_good();
    commit = 1'b1;
    step();
    commit = 1'b0;
    check("wait_pending", 32'(pending), 32'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    model_default();
    check("async_rst_pending", 32'(pending), 32'd0);
    check("async_rst_ready", 32'(load_ready), 32'd1);
    check_bus("async_rst_bus");
    #3 rst_n = 1'b1;
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("post_rst_no_swap", 32'(swap_done), 32'd0);
    check("post_rst_pending", 32'(pending), 32'd0);
    check_bus("post_rst_bus");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
